// File: rtl/issue_pkg.sv
// Shared entry layout and constants for the issue queue and its selection logic.
package issue_pkg;
    localparam int ENTRY_W        = 282;
    localparam int REG_W          = 6;
    localparam int SERIAL_REG_DEF = 63;
    localparam int RE1_LSB        = 199;
    localparam int RE2_LSB        = 205;
    localparam int RD_LSB         = 211;

    typedef struct packed {
        logic        sign;
        logic [63:0] pc;
        logic [5:0]  rd;
        logic [5:0]  re2;
        logic [5:0]  re1;
        logic [63:0] c;
        logic [63:0] b;
        logic [63:0] a;
        logic [4:0]  opsel;
        logic [1:0]  issue;
    } entry_t;

    function automatic logic is_serial(input logic [REG_W-1:0] rd, input int serial_reg);
        return rd == REG_W'(serial_reg);
    endfunction
endpackage

// File: rtl/issue_select.sv
// In-order issue selection: longest hazard-free prefix of the head-ordered window.
module issue_select
    import issue_pkg::*;
#(
    parameter int ISS_W      = 4,
    parameter int SERIAL_REG = SERIAL_REG_DEF
) (
    input  logic [ISS_W*ENTRY_W-1:0]   entries,
    input  logic [ISS_W-1:0]           avail,
    output logic [$clog2(ISS_W+1)-1:0] num,
    output logic [ISS_W-1:0]           mask,
    output logic [ISS_W*ENTRY_W-1:0]   sel_entries
);
    localparam int NUM_W = $clog2(ISS_W + 1);

    logic [REG_W-1:0]      rd;
    logic [REG_W-1:0]      re1;
    logic [REG_W-1:0]      re2;
    logic [(1<<REG_W)-1:0] busy;
    logic                  stop;

    always_comb begin
        mask = '0;
        busy = '0;
        stop = 1'b0;
        rd   = '0;
        re1  = '0;
        re2  = '0;
        for (int k = 0; k < ISS_W; k++) begin
            rd  = entries[k*ENTRY_W+RD_LSB  +: REG_W];
            re1 = entries[k*ENTRY_W+RE1_LSB +: REG_W];
            re2 = entries[k*ENTRY_W+RE2_LSB +: REG_W];
            // busy[0] is never set, so register 0 never creates a dependency.
            if (!avail[k] || busy[re1] || busy[re2] || (k != 0 && is_serial(rd, SERIAL_REG)))
                stop = 1'b1;
            if (!stop) begin
                mask[k] = 1'b1;
                if (rd != '0)
                    busy[rd] = 1'b1;
                if (is_serial(rd, SERIAL_REG))
                    stop = 1'b1;
            end
        end
        num = NUM_W'($countones(mask));
    end

    always_comb begin
        sel_entries = '0;
        for (int k = 0; k < ISS_W; k++)
            if (mask[k])
                sel_entries[k*ENTRY_W +: ENTRY_W] = entries[k*ENTRY_W +: ENTRY_W];
    end
endmodule

// File: rtl/issue_queue.sv
// Circular-buffer issue queue: compacted multi-lane dispatch, in-order hazard-aware issue.
module issue_queue
    import issue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DISP_W     = 4,
    parameter int ISS_W      = 4,
    parameter int SERIAL_REG = SERIAL_REG_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [DISP_W-1:0]         in_valid,
    input  logic [DISP_W*ENTRY_W-1:0] in_entry,
    output logic                      in_ready,
    input  logic                      issue_en,
    output logic [ISS_W-1:0]          out_valid,
    output logic [ISS_W*ENTRY_W-1:0]  out_entry,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NUM_W = $clog2(ISS_W + 1);

    entry_t                   mem_q [DEPTH];
    entry_t                   mem_d [DEPTH];
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [ISS_W-1:0]         out_valid_q, out_valid_d;
    logic [ISS_W*ENTRY_W-1:0] out_entry_q, out_entry_d;

    logic [ISS_W*ENTRY_W-1:0] head_entries;
    logic [ISS_W*ENTRY_W-1:0] sel_entries;
    logic [ISS_W-1:0]         avail;
    logic [ISS_W-1:0]         sel_mask;
    logic [NUM_W-1:0]         sel_num;
    logic [CNT_W-1:0]         n_acc, n_iss, slot;

    assign in_ready  = (CNT_W'(DEPTH) - count_q) >= CNT_W'(DISP_W);
    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign out_entry = out_entry_q;

    // Issue window is taken from registered storage, so same-edge dispatches are not eligible.
    always_comb begin
        head_entries = '0;
        avail        = '0;
        for (int k = 0; k < ISS_W; k++) begin
            head_entries[k*ENTRY_W +: ENTRY_W] = mem_q[head_q + PTR_W'(k)];
            avail[k] = issue_en && (CNT_W'(k) < count_q);
        end
    end

    issue_select #(
        .ISS_W      (ISS_W),
        .SERIAL_REG (SERIAL_REG)
    ) u_select (
        .entries     (head_entries),
        .avail       (avail),
        .num         (sel_num),
        .mask        (sel_mask),
        .sel_entries (sel_entries)
    );

    always_comb begin
        mem_d       = mem_q;
        out_entry_d = out_entry_q;
        out_valid_d = sel_mask;
        slot        = '0;
        n_iss       = CNT_W'(sel_num);
        n_acc       = in_ready ? CNT_W'($countones(in_valid)) : '0;
        if (in_ready) begin
            for (int i = 0; i < DISP_W; i++) begin
                if (in_valid[i]) begin
                    mem_d[tail_q + slot[PTR_W-1:0]] = entry_t'(in_entry[i*ENTRY_W +: ENTRY_W]);
                    slot = slot + CNT_W'(1);
                end
            end
        end
        for (int k = 0; k < ISS_W; k++)
            if (sel_mask[k])
                out_entry_d[k*ENTRY_W +: ENTRY_W] = sel_entries[k*ENTRY_W +: ENTRY_W];
        head_d  = head_q + PTR_W'(n_iss);
        tail_d  = tail_q + PTR_W'(n_acc);
        count_d = count_q + n_acc - n_iss;
        if (flush) begin
            mem_d       = mem_q;
            out_entry_d = out_entry_q;
            out_valid_d = '0;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= '0;
            out_entry_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_entry_q <= out_entry_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_issue_queue.sv
// Directed scenarios plus randomised traffic for issue_queue, checked against a queue model.
module tb_issue_queue;
    import issue_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DISP_W = 4;
    localparam int ISS_W  = 4;
    localparam int SERIAL = 63;
    localparam int EW     = ENTRY_W;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   flush = 1'b0;
    logic                   issue_en = 1'b0;
    logic                   in_ready;
    logic [DISP_W-1:0]      in_valid = '0;
    logic [DISP_W*EW-1:0]   in_entry = '0;
    logic [ISS_W-1:0]       out_valid;
    logic [ISS_W*EW-1:0]    out_entry;
    logic [CW-1:0]          count;

    int total = 0;
    int bad   = 0;

    entry_t              mq[$];
    logic [ISS_W-1:0]    m_valid = '0;
    logic [ISS_W*EW-1:0] m_entry = '0;

    issue_queue #(
        .DEPTH      (DEPTH),
        .DISP_W     (DISP_W),
        .ISS_W      (ISS_W),
        .SERIAL_REG (SERIAL)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_entry  (in_entry),
        .in_ready  (in_ready),
        .issue_en  (issue_en),
        .out_valid (out_valid),
        .out_entry (out_entry),
        .count     (count)
    );

    always #5 clock = ~clock;

    function automatic entry_t mk(input int rd, input int re1, input int re2);
        entry_t e;
        e.sign  = 1'($urandom);
        e.pc    = {$urandom, $urandom};
        e.rd    = 6'(rd);
        e.re2   = 6'(re2);
        e.re1   = 6'(re1);
        e.c     = {$urandom, $urandom};
        e.b     = {$urandom, $urandom};
        e.a     = {$urandom, $urandom};
        e.opsel = 5'($urandom);
        e.issue = 2'($urandom);
        return e;
    endfunction

    function automatic logic [DISP_W*EW-1:0] grp(input entry_t e0, input entry_t e1,
                                                 input entry_t e2, input entry_t e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic m_ready();
        return (DEPTH - mq.size()) >= DISP_W;
    endfunction

    // Apply one cycle of inputs and advance the model by the queue rules.
    task automatic cycle(input logic [DISP_W-1:0] v, input logic [DISP_W*EW-1:0] ents,
                         input logic ie, input logic fl);
        logic       rdy;
        int         n;
        logic [5:0] dests[$];
        entry_t     e;
        bit         hit;
        in_valid = v;
        in_entry = ents;
        issue_en = ie;
        flush    = fl;
        rdy      = m_ready();
        @(posedge clock);
        m_valid = '0;
        n = 0;
        if (fl) begin
            mq.delete();
        end else begin
            if (ie) begin
                for (int k = 0; k < ISS_W && k < mq.size(); k++) begin
                    e = mq[k];
                    hit = 0;
                    foreach (dests[j])
                        if (dests[j] != 6'd0 && (dests[j] == e.re1 || dests[j] == e.re2)) hit = 1;
                    if (hit || (k > 0 && e.rd == 6'(SERIAL))) break;
                    m_valid[k] = 1'b1;
                    m_entry[k*EW +: EW] = e;
                    n++;
                    dests.push_back(e.rd);
                    if (e.rd == 6'(SERIAL)) break;
                end
            end
            repeat (n) void'(mq.pop_front());
            if (rdy)
                for (int i = 0; i < DISP_W; i++)
                    if (v[i]) mq.push_back(entry_t'(ents[i*EW +: EW]));
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (out_valid !== 4'b0) begin bad++; $display("FAIL reset_valid got=%b want=0000", out_valid); end
        total++; if (out_entry !== '0) begin bad++; $display("FAIL reset_entry got nonzero want zero"); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_independent();
        entry_t e[4];
        for (int i = 0; i < 4; i++) e[i] = mk(i + 1, 0, 0);
        cycle(4'b1111, grp(e[0], e[1], e[2], e[3]), 1'b1, 1'b0);
        total++; if (count !== 4'd4) begin bad++; $display("FAIL indep_count1 got=%0d want=4", count); end
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL indep_early got=%b want=0000", out_valid); end
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b1111) begin bad++; $display("FAIL indep_valid got=%b want=1111", out_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL indep_count2 got=%0d want=0", count); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_entry[k*EW +: EW] !== e[k]) begin
                bad++; $display("FAIL indep_lane%0d got=%h want=%h", k, out_entry[k*EW +: EW], e[k]);
            end
        end
    endtask

    task automatic test_sparse();
        entry_t a, b;
        a = mk(1, 0, 0);
        b = mk(2, 0, 0);
        cycle(4'b1010, grp(mk(9, 0, 0), a, mk(10, 0, 0), b), 1'b0, 1'b0);
        total++; if (count !== 4'd2) begin bad++; $display("FAIL sparse_count got=%0d want=2", count); end
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b0011) begin bad++; $display("FAIL sparse_valid got=%b want=0011", out_valid); end
        total++; if (out_entry[0 +: EW] !== a) begin bad++; $display("FAIL sparse_lane0 got=%h want=%h", out_entry[0 +: EW], a); end
        total++; if (out_entry[EW +: EW] !== b) begin bad++; $display("FAIL sparse_lane1 got=%h want=%h", out_entry[EW +: EW], b); end
    endtask

    task automatic test_hazard();
        entry_t a, b, c;
        a = mk(5, 0, 0);
        b = mk(6, 5, 0);
        c = mk(7, 0, 0);
        cycle(4'b0111, grp(a, b, c, mk(1, 0, 0)), 1'b1, 1'b0);
        total++; if (count !== 4'd3) begin bad++; $display("FAIL haz_count got=%0d want=3", count); end
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL haz_valid1 got=%b want=0001", out_valid); end
        total++; if (out_entry[0 +: EW] !== a) begin bad++; $display("FAIL haz_first got=%h want=%h", out_entry[0 +: EW], a); end
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b0011) begin bad++; $display("FAIL haz_valid2 got=%b want=0011", out_valid); end
        total++; if (out_entry[0 +: EW] !== b) begin bad++; $display("FAIL haz_lane0 got=%h want=%h", out_entry[0 +: EW], b); end
        total++; if (out_entry[EW +: EW] !== c) begin bad++; $display("FAIL haz_lane1 got=%h want=%h", out_entry[EW +: EW], c); end
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL empty_issue got=%b want=0000", out_valid); end
    endtask

    task automatic test_full_wrap();
        entry_t f[6];
        entry_t g[4];
        logic [ISS_W*EW-1:0] snap;
        for (int i = 0; i < 6; i++) f[i] = mk(i + 1, 0, 0);
        for (int i = 0; i < 4; i++) g[i] = mk(i + 10, 0, 0);
        cycle('0, '0, 1'b0, 1'b1);
        cycle(4'b1111, grp(f[0], f[1], f[2], f[3]), 1'b0, 1'b0);
        cycle(4'b0011, grp(f[4], f[5], mk(1, 0, 0), mk(1, 0, 0)), 1'b0, 1'b0);
        total++; if (count !== 4'd6) begin bad++; $display("FAIL full_count got=%0d want=6", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", in_ready); end
        cycle(4'b1111, grp(mk(20, 0, 0), mk(21, 0, 0), mk(22, 0, 0), mk(23, 0, 0)), 1'b0, 1'b0);
        total++; if (count !== 4'd6) begin bad++; $display("FAIL full_ignored got=%0d want=6", count); end
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b1111) begin bad++; $display("FAIL full_drain1 got=%b want=1111", out_valid); end
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b0011) begin bad++; $display("FAIL full_drain2 got=%b want=0011", out_valid); end
        total++; if (out_entry[EW +: EW] !== f[5]) begin bad++; $display("FAIL full_last got=%h want=%h", out_entry[EW +: EW], f[5]); end
        cycle(4'b1111, grp(g[0], g[1], g[2], g[3]), 1'b0, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b1111) begin bad++; $display("FAIL wrap_valid got=%b want=1111", out_valid); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_entry[k*EW +: EW] !== g[k]) begin
                bad++; $display("FAIL wrap_lane%0d got=%h want=%h", k, out_entry[k*EW +: EW], g[k]);
            end
        end
        snap = out_entry;
        cycle('0, '0, 1'b0, 1'b0);
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL hold_valid got=%b want=0000", out_valid); end
        total++; if (out_entry !== snap) begin bad++; $display("FAIL hold_entry lane0 got=%h want=%h", out_entry[0 +: EW], snap[0 +: EW]); end
    endtask

    task automatic test_serial();
        entry_t s, p[4];
        s = mk(SERIAL, 0, 0);
        for (int i = 0; i < 4; i++) p[i] = mk(i + 1, 0, 0);
        cycle(4'b1111, grp(s, p[0], p[1], p[2]), 1'b0, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL ser_head got=%b want=0001", out_valid); end
        total++; if (out_entry[0 +: EW] !== s) begin bad++; $display("FAIL ser_lane0 got=%h want=%h", out_entry[0 +: EW], s); end
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b0111) begin bad++; $display("FAIL ser_follow got=%b want=0111", out_valid); end
        cycle(4'b1111, grp(p[0], p[1], s, p[3]), 1'b0, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b0011) begin bad++; $display("FAIL ser_mid1 got=%b want=0011", out_valid); end
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL ser_mid2 got=%b want=0001", out_valid); end
        total++; if (out_entry[0 +: EW] !== s) begin bad++; $display("FAIL ser_mid_lane got=%h want=%h", out_entry[0 +: EW], s); end
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_entry[0 +: EW] !== p[3]) begin bad++; $display("FAIL ser_tail got=%h want=%h", out_entry[0 +: EW], p[3]); end
    endtask

    task automatic test_flush();
        entry_t x;
        x = mk(3, 0, 0);
        cycle(4'b1111, grp(mk(1, 0, 0), mk(2, 0, 0), mk(3, 0, 0), mk(4, 0, 0)), 1'b0, 1'b0);
        cycle(4'b0001, grp(mk(5, 0, 0), mk(1, 0, 0), mk(1, 0, 0), mk(1, 0, 0)), 1'b0, 1'b0);
        total++; if (count !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d want=5", count); end
        cycle(4'b1111, grp(mk(6, 0, 0), mk(7, 0, 0), mk(8, 0, 0), mk(9, 0, 0)), 1'b1, 1'b1);
        total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count); end
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL flush_valid got=%b want=0000", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", in_ready); end
        cycle(4'b0001, grp(x, x, x, x), 1'b0, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
        total++; if (out_valid !== 4'b0001) begin bad++; $display("FAIL flush_after got=%b want=0001", out_valid); end
        total++; if (out_entry[0 +: EW] !== x) begin bad++; $display("FAIL flush_after_lane got=%h want=%h", out_entry[0 +: EW], x); end
    endtask

    task automatic test_reset_mid();
        entry_t y;
        y = mk(2, 0, 0);
        cycle(4'b1111, grp(mk(1, 0, 0), mk(2, 0, 0), mk(3, 0, 0), mk(4, 0, 0)), 1'b0, 1'b0);
        cycle(4'b1111, grp(mk(5, 0, 0), mk(6, 0, 0), mk(7, 0, 0), mk(8, 0, 0)), 1'b1, 1'b0);
        total++; if (out_valid !== 4'b1111) begin bad++; $display("FAIL rmid_pre got=%b want=1111", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rmid_valid got=%b want=0000", out_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", count); end
        total++; if (out_entry !== '0) begin bad++; $display("FAIL rmid_entry got nonzero want zero"); end
        #2 reset_n = 1'b1;
        mq.delete();
        m_valid = '0;
        cycle(4'b0001, grp(y, y, y, y), 1'b0, 1'b0);
        total++; if (count !== 4'd1) begin bad++; $display("FAIL rmid_first got=%0d want=1", count); end
    endtask

    task automatic test_random();
        entry_t le[4];
        int rd;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                rd = ($urandom_range(0, 15) == 0) ? SERIAL : int'($urandom_range(0, 7));
                le[i] = mk(rd, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            end
            cycle(4'($urandom), grp(le[0], le[1], le[2], le[3]),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
            total++;
            if (count !== CW'(mq.size())) begin
                bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", c, count, mq.size());
            end
            total++;
            if (in_ready !== m_ready()) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, in_ready, m_ready());
            end
            total++;
            if (out_valid !== m_valid) begin
                bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", c, out_valid, m_valid);
            end
            for (int k = 0; k < ISS_W; k++) begin
                if (m_valid[k]) begin
                    total++;
                    if (out_entry[k*EW +: EW] !== m_entry[k*EW +: EW]) begin
                        bad++;
                        $display("FAIL rnd_lane%0d cyc=%0d got=%h want=%h", k, c,
                                 out_entry[k*EW +: EW], m_entry[k*EW +: EW]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_sparse();
        test_hazard();
        test_full_wrap();
        test_serial();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, >= DISP_W.
REQ-002 Parameter DISP_W, default 4, dispatch lanes per cycle.
REQ-003 Parameter ISS_W, default 4, issue lanes per cycle.
REQ-004 Parameter SERIAL_REG, default 63, rd value marking a serialising entry.
REQ-005 clock  input  1  sole clock, rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous queue clear.
REQ-008 in_valid  input  DISP_W  per-lane dispatch valid.
REQ-009 in_entry  input  DISP_W x ENTRY_W  packed entry per lane.
REQ-010 in_ready  output  1  queue accepts a dispatch group this cycle.
REQ-011 issue_en  input  1  downstream permits issue this cycle.
REQ-012 out_valid  output  ISS_W  registered per-lane issue valid.
REQ-013 out_entry  output  ISS_W x ENTRY_W  registered issued entries, lane 0 oldest.
REQ-014 count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Storage: circular buffer, head/tail pointers of clog2(DEPTH) bits wrapping modulo DEPTH, plus count; empty = count 0, full = count DEPTH.
REQ-016 in_ready = (DEPTH - count) >= DISP_W, combinational from registered count only.
REQ-017 Dispatch: if in_ready and any in_valid, valid lanes written at tail in ascending lane order, compacted (invalid lanes skip no slots); tail and count advance by popcount(in_valid).
REQ-018 in_valid while in_ready=0: group ignored entirely, no partial write; source holds.
REQ-019 Issue selection (issue_en=1): oldest-first prefix of up to min(ISS_W, count) entries from head; scan stops at first entry that fails the hazard rule; entries never issue out of order.
REQ-020 Hazard rule: entry k blocked if its re1 or re2 equals rd of any earlier-selected entry this cycle and that rd != 0.
REQ-021 Serialising: entry with rd == SERIAL_REG issues only in lane 0 and ends the group.
REQ-022 Selected entries loaded into out_entry lanes 0.., out_valid set for them, remaining lanes 0; head advances and count decreases by number issued, same edge.
REQ-023 issue_en=0: out_valid all 0 next cycle, no pop; out_entry holds.
REQ-024 Latency: entry dispatched at edge N is earliest visible on out_valid after edge N+1; same-cycle dispatch entries not eligible for issue.
REQ-025 Simultaneous dispatch and issue: count_next = count + accepted - issued; both pointer updates apply same edge.
REQ-026 Head head wrap: selection indexes (head+k) mod DEPTH; groups straddling wrap issue in age order.
REQ-027 flush=1: head=tail=count=0, out_valid=0 next cycle; dispatch and issue that cycle discarded; flush dominates.
REQ-028 Empty queue with issue_en=1: out_valid=0, pointers unchanged.

Reset
REQ-029 reset_n low asynchronously sets head=0, tail=0, count=0, out_valid=0, out_entry=0; in_ready therefore 1.
REQ-030 Reset mid-operation discards all queued and in-flight entries; storage array need not reset.
REQ-031 First dispatch accepted on first rising edge after reset_n deasserts.

Structure
REQ-032 Shared package issue_pkg: ENTRY_W=282; field ranges issue[1:0], opsel[6:2], A[70:7], B[134:71], C[198:135], re1[204:199], re2[210:205], rd[216:211], PC[280:217], sign[281]; SERIAL_REG default.
REQ-033 One sub-module issue_select: combinational, takes ISS_W head-ordered entries plus availability mask, returns issue count and lane mask.
REQ-034 Storage, pointers, count, output registers in issue_queue.

Verification
REQ-035 Reset then dispatch 4 independent entries (rd 1..4, sources 0), issue_en=1 -> two edges later out_valid=1111, lanes in dispatch order, count 0.
REQ-036 Dispatch in_valid=1010 -> count +2, two entries contiguous at tail; issued in lanes 0,1.
REQ-037 Entries rd=5; re1=5; rd=7 queued -> first cycle out_valid=0001, next cycle 0011 with re1=5 entry in lane 0.
REQ-038 Fill to count 6 with DEPTH 8, issue_en=0 -> in_ready=0, group ignored, count stays 6; head at 6 then issue 4 -> entries 6,7,0,1 in order.
REQ-039 Entry rd=63 at head with 3 followers -> out_valid=0001 that cycle, followers next.
REQ-040 flush asserted with count 5 and simultaneous dispatch -> count 0, out_valid 0, in_ready 1 next cycle; reset_n pulse mid-issue -> outputs 0 immediately.
